load_store_unit: RTL and testbench

Word-memory initiator between the core's execute/memory stage and the 32-bit word-addressed data memory (combinational read, single-cycle synchronous write). Accepts one RV32I load/store request at a time over a valid/ready handshake and converts byte addresses to word indices. Performs LB/LH/LW/LBU/LHU extraction with sign or zero extension. Implements SB/SH as a read-modify-write, because the memory has no byte enables.

---
 rtl/load_store_unit_pkg.sv | 29 ++
 rtl/load_store_unit_if.sv | 28 ++
 rtl/load_store_unit_byte_lane.sv | 43 ++++
 rtl/load_store_unit.sv | 105 ++++++++++
 tb/tb_load_store_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} lsu_state_e;

  // Unknown width codes, unsigned stores and misaligned H/W are rejected.
  function automatic logic req_illegal(input logic we, input logic [2:0] f3,
                                       input logic [1:0] a);
    logic ill;
    case (f3)
      F3_B:    ill = 1'b0;
      F3_H:    ill = a[0];
      F3_W:    ill = (a != 2'b00);
      F3_BU:   ill = we;
      F3_HU:   ill = we | a[0];
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-side bus of the load/store unit.
interface load_store_unit_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wd;
  logic [XLEN-1:0] mem_rd;

  // LSU side
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wd
  );

  // Core + memory side
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/load_store_unit_byte_lane.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_byte_lane
  import lsu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      lane_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] ld_data_o,
  output logic [XLEN-1:0] st_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{lane_i, 3'b000} +: 8];
  assign half_sel = word_i[{lane_i[1], 4'b0000} +: 16];

  // Little-endian extraction; B/H sign-extend, BU/HU zero-extend.
  always_comb begin
    ld_data_o = word_i;
    case (funct3_i)
      F3_B:    ld_data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_BU:   ld_data_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_H:    ld_data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_HU:   ld_data_o = {{(XLEN-16){1'b0}}, half_sel};
      default: ld_data_o = word_i;
    endcase
  end

  // Replace only the addressed byte/half of the old word.
  always_comb begin
    st_word_o = word_i;
    case (funct3_i)
      F3_B:    st_word_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
      F3_H:    st_word_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: st_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store initiator for a word memory without
// byte enables; sub-word stores go through read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic clk,
  input  logic rst_in,
  load_store_unit_if.slave bus
);

  lsu_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  // Holds the load result, or the merged word for SB/SH.
  logic [XLEN-1:0] data_q, data_d;

  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] st_word;
  logic            sw_access;

  lsu_byte_lane #(.XLEN(XLEN)) u_lane (
    .word_i    (bus.mem_rd),
    .lane_i    (addr_q[1:0]),
    .funct3_i  (f3_q),
    .wdata_i   (wdata_q),
    .ld_data_o (ld_data),
    .st_word_o (st_word)
  );

  // State and request/result registers.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end

  // Next-state: accept in IDLE, one memory access, optional merge write, respond.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    err_d   = err_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          data_d  = '0;
          err_d   = req_illegal(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
          state_d = err_d ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          data_d  = ld_data;
          state_d = RESP;
        end else if (f3_q == F3_W) begin
          state_d = RESP;
        end else begin
          data_d  = st_word;
          state_d = MERGE_WR;
        end
      end
      MERGE_WR: state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and registers only; nothing from req_* reaches mem_*.
  assign sw_access     = (state_q == ACCESS) && we_q && (f3_q == F3_W);
  assign bus.req_ready = rst_in && (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = (state_q == RESP) && err_q;
  assign bus.rsp_rdata = ((state_q == RESP) && !we_q && !err_q) ? data_q : '0;
  assign bus.mem_we    = sw_access || (state_q == MERGE_WR);
  assign bus.mem_addr  = {2'b00, addr_q[XLEN-1:2]};
  assign bus.mem_wd    = (state_q == MERGE_WR) ? data_q :
                         sw_access             ? wdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_in = 1'b0;
  logic mem_init = 1'b0;
  logic [31:0] mem [16];

  int checks = 0;
  int errors = 0;

  // results of the last run_req
  int          r_lat, r_wcnt, r_wk, r_busy;
  logic [31:0] r_rdata, r_wa, r_wd;
  logic        r_err;

  load_store_unit_if #(.XLEN(32)) bus ();

  load_store_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.mem_rd = mem[bus.mem_addr[3:0]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[1] <= 32'hA1B2C3D4;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[3:0]] <= bus.mem_wd;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic init_mem();
    @(negedge clk) mem_init = 1'b1;
    @(negedge clk) mem_init = 1'b0;
  endtask

  // Issue one request and watch until the response (bounded).
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    check("ready_before", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    r_lat = 0; r_wcnt = 0; r_wk = 0; r_busy = 0;
    r_rdata = 32'hDEADBEEF; r_err = 1'bx; r_wa = 32'hx; r_wd = 32'hx;
    for (int k = 1; k <= 10 && r_lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      if (bus.req_ready) r_busy++;
      if (bus.mem_we) begin
        r_wcnt++; r_wk = k; r_wa = bus.mem_addr; r_wd = bus.mem_wd;
      end
      if (bus.rsp_valid) begin
        r_lat = k; r_rdata = bus.rsp_rdata; r_err = bus.rsp_err;
      end
    end
  endtask

  task automatic do_chk(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_wcnt);
    run_req(we, f3, addr, wd);
    check({tag, "_lat"},   r_lat, exp_lat);
    check({tag, "_rdata"}, r_rdata, exp_rd);
    check({tag, "_err"},   {31'b0, r_err}, {31'b0, exp_err});
    check({tag, "_wcnt"},  r_wcnt, exp_wcnt);
    check({tag, "_busy"},  r_busy, 0);
  endtask

  // per-cycle expectations for the held-valid back-to-back sequence
  logic [6:1] exp_rdy = 6'b100100;
  logic [6:1] exp_rv  = 6'b010010;
  logic [6:1] exp_mwe = 6'b001000;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ready",  {31'b0, bus.req_ready}, 32'd0);
    check("rst_rvalid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_err",    {31'b0, bus.rsp_err},   32'd0);
    check("rst_mwe",    {31'b0, bus.mem_we},    32'd0);
    check("rst_rdata",  bus.rsp_rdata, 32'd0);
    check("rst_maddr",  bus.mem_addr,  32'd0);
    check("rst_mwd",    bus.mem_wd,    32'd0);
    rst_in = 1'b1;
    init_mem();
    check("ready_idle", {31'b0, bus.req_ready}, 32'd1);

    // loads
    do_chk("lw4",  1'b0, F3_W,  32'h4, 32'h0, 2, 32'hA1B2C3D4, 1'b0, 0);
    do_chk("lb7",  1'b0, F3_B,  32'h7, 32'h0, 2, 32'hFFFFFFA1, 1'b0, 0);
    do_chk("lbu7", 1'b0, F3_BU, 32'h7, 32'h0, 2, 32'h000000A1, 1'b0, 0);
    do_chk("lh6",  1'b0, F3_H,  32'h6, 32'h0, 2, 32'hFFFFA1B2, 1'b0, 0);
    do_chk("lhu4", 1'b0, F3_HU, 32'h4, 32'h0, 2, 32'h0000C3D4, 1'b0, 0);
    do_chk("lb4",  1'b0, F3_B,  32'h4, 32'h0, 2, 32'hFFFFFFD4, 1'b0, 0);
    do_chk("lbu5", 1'b0, F3_BU, 32'h5, 32'h0, 2, 32'h000000C3, 1'b0, 0);

    // SB read-modify-write
    do_chk("sb5", 1'b1, F3_B, 32'h5, 32'h000000EE, 3, 32'h0, 1'b0, 1);
    check("sb5_wk",   r_wk, 2);
    check("sb5_waddr", r_wa, 32'd1);
    check("sb5_wdata", r_wd, 32'hA1B2EED4);
    do_chk("lw4_after_sb", 1'b0, F3_W, 32'h4, 32'h0, 2, 32'hA1B2EED4, 1'b0, 0);

    // SH upper half
    do_chk("sh6", 1'b1, F3_H, 32'h6, 32'h0000BEEF, 3, 32'h0, 1'b0, 1);
    check("sh6_wdata", r_wd, 32'hBEEFEED4);

    // errors
    do_chk("err_sh3",  1'b1, F3_H,   32'h3, 32'h0000FFFF, 1, 32'h0, 1'b1, 0);
    do_chk("err_lw2",  1'b0, F3_W,   32'h2, 32'h0, 1, 32'h0, 1'b1, 0);
    do_chk("err_f011", 1'b0, 3'b011, 32'h4, 32'h0, 1, 32'h0, 1'b1, 0);
    do_chk("err_sbu",  1'b1, F3_BU,  32'h4, 32'h0, 1, 32'h0, 1'b1, 0);
    check("mem1_after_err", mem[1], 32'hBEEFEED4);

    // back-to-back with req_valid held high: LW 0x4 then SW 0x8
    init_mem();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = F3_W;
    bus.req_addr = 32'h4; bus.req_wdata = 32'h0;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("b2b_ready_%0d", k), {31'b0, bus.req_ready}, {31'b0, exp_rdy[k]});
      check($sformatf("b2b_rvalid_%0d", k), {31'b0, bus.rsp_valid}, {31'b0, exp_rv[k]});
      check($sformatf("b2b_mwe_%0d", k), {31'b0, bus.mem_we}, {31'b0, exp_mwe[k]});
      if (k == 2) check("b2b_lw_rdata", bus.rsp_rdata, 32'hA1B2C3D4);
      if (k == 4) begin
        check("b2b_sw_maddr", bus.mem_addr, 32'd2);
        check("b2b_sw_mwd",   bus.mem_wd,   32'h12345678);
      end
      if (k == 1) begin
        bus.req_we = 1'b1; bus.req_addr = 32'h8; bus.req_wdata = 32'h12345678;
      end
      if (k == 4) bus.req_valid = 1'b0;
    end
    check("b2b_mem2", mem[2], 32'h12345678);

    // reset during MERGE_WR aborts the SH
    init_mem();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_H;
    bus.req_addr = 32'h4; bus.req_wdata = 32'h0000BEEF;
    @(posedge clk);
    @(negedge clk) bus.req_valid = 1'b0;
    check("abort_access_mwe", {31'b0, bus.mem_we}, 32'd0);
    @(negedge clk);
    check("abort_merge_mwe", {31'b0, bus.mem_we}, 32'd1);
    rst_in = 1'b0;
    #1;
    check("abort_mwe_drop", {31'b0, bus.mem_we}, 32'd0);
    check("abort_ready_rst", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clk) rst_in = 1'b1;
    #1;
    check("abort_ready_after", {31'b0, bus.req_ready}, 32'd1);
    r_lat = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.mem_we) r_lat++;
    end
    check("abort_no_rsp", r_lat, 0);
    check("abort_mem1", mem[1], 32'hA1B2C3D4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
